// File: rtl/spart_pkg.sv
// Shared constants for the SPART baud-rate generator.
// Holds the bus byte width, the divisor width and the divisor values for the
// standard baud rates at 100 MHz with 16x oversampling. Each value is
// round(100e6 / (16 * baud)) - 1, because a divisor D yields a tick period of
// D+1 clocks.
package spart_pkg;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 2 * DATA_W;

    localparam logic [DIV_W-1:0] DIV_4800    = 16'h0515;
    localparam logic [DIV_W-1:0] DIV_9600    = 16'h028A;
    localparam logic [DIV_W-1:0] DIV_19200   = 16'h0145;
    localparam logic [DIV_W-1:0] DIV_38400   = 16'h00A2;
    localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_38400;

endpackage

// File: rtl/spart_tick_div.sv
// Generic reloadable down-counter.
// When en is high the counter steps down by one. When it is at zero it
// reloads reload_val instead of wrapping. load takes priority over en and
// forces load_val in. zero flags the terminal count so the parent can turn it
// into a tick.
//   clk, rst   : clock, asynchronous active-high reset (counter <- RST_VAL)
//   en         : count enable; the counter holds when low
//   load       : synchronous load of load_val
//   load_val   : value forced in by load
//   reload_val : value taken on the step after zero
//   zero       : counter currently equals zero
module spart_tick_div #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] reload_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = zero ? reload_val : (cnt_q - W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart_baud_gen.sv
// Programmable baud-rate generator for the SPART.
// The 16-bit divisor is written as two bytes. The low byte only lands in a
// shadow register. The high-byte write commits {high, shadow} and restarts
// both counters, so a rate change never produces a runt period.
//   clk, rst   : clock, asynchronous active-high reset
//   run        : count enable; ticks are 0 while low
//   div_lo_we  : write low byte into the shadow
//   div_hi_we  : write high byte and commit the divisor
//   div_data   : byte written by either strobe
//   divisor    : committed divisor readback
//   os_tick    : one-cycle pulse every divisor+1 counting clocks
//   baud_tick  : one-cycle pulse on every OVERSAMPLE-th os_tick
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int                    DATA_W      = spart_pkg::DATA_W,
    parameter int                    OVERSAMPLE  = 16,
    parameter logic [2*DATA_W-1:0]   DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  div_lo_we,
    input  logic                  div_hi_we,
    input  logic [DATA_W-1:0]     div_data,
    output logic [2*DATA_W-1:0]   divisor,
    output logic                  os_tick,
    output logic                  baud_tick
);

    localparam int DW   = 2 * DATA_W;
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_TOP = OS_W'(OVERSAMPLE - 1);

    logic [DW-1:0]     div_q,       div_d;
    logic [DATA_W-1:0] lo_shadow_q, lo_shadow_d;
    logic              os_tick_q,   os_tick_d;
    logic              baud_tick_q, baud_tick_d;

    logic [DW-1:0]     commit_val;
    logic              div_zero;
    logic              os_zero;
    logic              os_tick_pre;
    logic              baud_pre;

    // A simultaneous lo+hi write commits the old shadow byte.
    assign commit_val = {div_data, lo_shadow_q};

    // A commit suppresses the tick of that cycle and restarts both stages.
    assign os_tick_pre = run && !div_hi_we && div_zero;
    assign baud_pre    = os_tick_pre && os_zero;

    always_comb begin
        div_d       = div_q;
        lo_shadow_d = lo_shadow_q;
        if (div_lo_we) begin
            lo_shadow_d = div_data;
        end
        if (div_hi_we) begin
            div_d = commit_val;
        end
        os_tick_d   = os_tick_pre;
        baud_tick_d = baud_pre;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= DEFAULT_DIV;
            lo_shadow_q <= DEFAULT_DIV[DATA_W-1:0];
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            lo_shadow_q <= lo_shadow_d;
            os_tick_q   <= os_tick_d;
            baud_tick_q <= baud_tick_d;
        end
    end

    spart_tick_div #(
        .W       (DW),
        .RST_VAL (DEFAULT_DIV)
    ) u_div_stage (
        .clk        (clk),
        .rst        (rst),
        .en         (run),
        .load       (div_hi_we),
        .load_val   (commit_val),
        .reload_val (div_q),
        .zero       (div_zero)
    );

    // Advances once per oversample tick; the cycle it sits at zero is the
    // baud tick. With OVERSAMPLE=1 it stays at zero permanently.
    spart_tick_div #(
        .W       (OS_W),
        .RST_VAL (OS_TOP)
    ) u_os_stage (
        .clk        (clk),
        .rst        (rst),
        .en         (os_tick_pre),
        .load       (div_hi_we),
        .load_val   (OS_TOP),
        .reload_val (OS_TOP),
        .zero       (os_zero)
    );

    assign divisor   = div_q;
    assign os_tick   = os_tick_q;
    assign baud_tick = baud_tick_q;

endmodule

// File: tb/tb_spart_baud_gen.sv
// Scoreboarded bench for spart_baud_gen. The stimulus side models the
// generator as "counting clocks elapsed since the last commit". It pushes the
// expected outputs for every edge. A monitor on the falling edge pops and
// compares them.
module tb_spart_baud_gen;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        div_lo_we;
    logic        div_hi_we;
    logic [7:0]  div_data;
    logic [15:0] divisor;
    logic        os_tick;
    logic        baud_tick;

    spart_baud_gen #(
        .DATA_W      (8),
        .OVERSAMPLE  (OS),
        .DEFAULT_DIV (16'h00A2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .div_lo_we (div_lo_we),
        .div_hi_we (div_hi_we),
        .div_data  (div_data),
        .divisor   (divisor),
        .os_tick   (os_tick),
        .baud_tick (baud_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] div;
        logic        os;
        logic        baud;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference state: committed divisor, shadow byte, and the number of
    // counting clocks since the last commit or reset.
    logic [15:0] m_div;
    logic [7:0]  m_sh;
    longint      m_n;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_div = 16'h00A2;
        m_sh  = 8'hA2;
        m_n   = 0;
    endtask

    // One clock: apply inputs, take the edge, predict and queue.
    task automatic cyc(input logic r, input logic lo, input logic hi, input logic [7:0] d);
        exp_t e;
        longint p;
        run = r; div_lo_we = lo; div_hi_we = hi; div_data = d;
        @(posedge clk);
        e.os = 1'b0; e.baud = 1'b0;
        if (hi) begin
            m_div = {d, m_sh};
            m_n   = 0;
        end else if (r) begin
            m_n++;
            p = longint'(m_div) + 1;
            e.os   = ((m_n % p) == 0);
            e.baud = ((m_n % (p * OS)) == 0);
        end
        if (lo) m_sh = d;
        e.div = m_div;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_divisor"}, 32'(divisor), 32'h00A2);
        check({tag, "_os"},      32'(os_tick), 32'h0);
        check({tag, "_baud"},    32'(baud_tick), 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("divisor",   32'(divisor),   32'(e.div));
            check("os_tick",   32'(os_tick),   32'(e.os));
            check("baud_tick", 32'(baud_tick), 32'(e.baud));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; run = 1'b0; div_lo_we = 1'b0; div_hi_we = 1'b0; div_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;

        // Some counting first, then a reset in the middle of a cycle.
        run_n(50);
        @(negedge clk); #1;
        rst = 1'b1; #1;
        check_reset_state("midrst");
        rst = 1'b0;
        model_reset();
        // Defaults: os every 163, baud every 2608.
        run_n(2 * 2608 + 5);

        // Byte load D=4.
        cyc(1'b1, 1'b1, 1'b0, 8'h04);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        run_n(170);

        // D=0: os every clock, baud one in sixteen.
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        run_n(64);

        // Pause mid-count with D=4.
        cyc(1'b1, 1'b1, 1'b0, 8'h04);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        run_n(2);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        run_n(25);

        // Simultaneous writes: commit uses the old shadow.
        cyc(1'b1, 1'b1, 1'b0, 8'h10);
        cyc(1'b1, 1'b1, 1'b1, 8'h01);
        run_n(30);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        run_n(40);

        // Async reset while a high-byte write is pending; the write is lost.
        @(negedge clk); #1;
        div_hi_we = 1'b1; div_data = 8'h37;
        #1 rst = 1'b1;
        #1 check_reset_state("hirst");
        rst = 1'b0;
        #1 div_hi_we = 1'b0;
        model_reset();
        run_n(400);

        // Random traffic with small divisors so ticks stay frequent.
        for (int i = 0; i < 3000; i++) begin
            logic r, lo, hi;
            logic [7:0] d;
            r  = ($urandom_range(0, 9) != 0);
            lo = ($urandom_range(0, 29) == 0);
            hi = ($urandom_range(0, 59) == 0);
            d  = (hi && !lo) ? (($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00)
                             : 8'($urandom_range(0, 7));
            cyc(r, lo, hi, d);
        end

        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
